// File: rtl/if_id_decode_stage.sv
// IF/ID pipeline register for the RV32I core: one-slot skid-free stage that registers
// the instruction, its PC, split fields and the generated immediate. Optional macro: IFID_ILLEGAL_DET_EN.
module if_id_decode_stage #(
   parameter int          PC_W      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr_in,
   input  logic [PC_W-1:0] pc_in,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     instr_out,
   output logic [PC_W-1:0] pc_out,
   output logic [6:0]      opcode,
   output logic [4:0]      rd,
   output logic [2:0]      funct3,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [6:0]      funct7,
   output logic [31:0]     imm,
   output logic [19:0]     imm_u_raw,
   output logic [2:0]      imm_type
`ifdef IFID_ILLEGAL_DET_EN
   ,
   output logic            illegal
`endif
);

   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_SYSTEM = 7'h73;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_REG    = 7'h33;

   localparam logic [2:0] TYPE_R = 3'd0;
   localparam logic [2:0] TYPE_I = 3'd1;
   localparam logic [2:0] TYPE_S = 3'd2;
   localparam logic [2:0] TYPE_B = 3'd3;
   localparam logic [2:0] TYPE_U = 3'd4;
   localparam logic [2:0] TYPE_J = 3'd5;

   logic        load;
   logic        update;
   logic [31:0] dec_instr;
   logic [2:0]  dec_type;
   logic [31:0] dec_imm;
   logic        dec_illegal;

   assign in_ready = !out_valid || out_ready || flush;
   assign load     = in_valid && in_ready && !flush;
   assign update   = rst || flush || load;

   // Reset and flush reuse the normal decode path by feeding it the NOP encoding.
   assign dec_instr = (rst || flush) ? NOP_INSTR : instr_in;

   always_comb begin
      dec_type    = TYPE_R;
      dec_illegal = 1'b0;
      case (dec_instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: dec_type = TYPE_I;
         OP_STORE:                            dec_type = TYPE_S;
         OP_BRANCH:                           dec_type = TYPE_B;
         OP_LUI, OP_AUIPC:                    dec_type = TYPE_U;
         OP_JAL:                              dec_type = TYPE_J;
         OP_REG:                              dec_type = TYPE_R;
         default:                             dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      dec_imm = 32'h0;
      case (dec_type)
         TYPE_I: dec_imm = {{20{dec_instr[31]}}, dec_instr[31:20]};
         TYPE_S: dec_imm = {{20{dec_instr[31]}}, dec_instr[31:25], dec_instr[11:7]};
         TYPE_B: dec_imm = {{19{dec_instr[31]}}, dec_instr[31], dec_instr[7],
                            dec_instr[30:25], dec_instr[11:8], 1'b0};
         TYPE_U: dec_imm = {dec_instr[31:12], 12'h000};
         TYPE_J: dec_imm = {{11{dec_instr[31]}}, dec_instr[31], dec_instr[19:12],
                            dec_instr[20], dec_instr[30:21], 1'b0};
         default: dec_imm = 32'h0;
      endcase
   end

   // Flush wins over load and stall; a drain without a new load just empties the slot.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_out <= '0;
      end else if (load) begin
         pc_out <= pc_in;
      end
   end

   always_ff @(posedge clk) begin
      if (update) begin
         instr_out <= dec_instr;
         opcode    <= dec_instr[6:0];
         rd        <= dec_instr[11:7];
         funct3    <= dec_instr[14:12];
         rs1       <= dec_instr[19:15];
         rs2       <= dec_instr[24:20];
         funct7    <= dec_instr[31:25];
         imm_u_raw <= dec_instr[31:12];
         imm       <= dec_imm;
         imm_type  <= dec_type;
      end
   end

`ifdef IFID_ILLEGAL_DET_EN
   always_ff @(posedge clk) begin
      if (update) begin
         illegal <= dec_illegal;
      end
   end
`else
   logic unused_illegal;
   assign unused_illegal = dec_illegal;
`endif

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Directed self-checking bench for if_id_decode_stage; build with IFID_ILLEGAL_DET_EN
// defined to also exercise the illegal-opcode flag.
module tb_if_id_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr_in;
   logic [31:0] pc_in;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic [19:0] imm_u_raw;
   logic [2:0]  imm_type;
`ifdef IFID_ILLEGAL_DET_EN
   logic        illegal;
`endif

   int total = 0;
   int bad   = 0;

   // LUI, ADDI, BEQ, JAL, SW, SUB with hand-decoded fields
   logic [31:0] v_instr [6] = '{32'h123450B7, 32'hFFF00113, 32'hFE000EE3, 32'hFF9FF06F, 32'hFE20AE23, 32'h402081B3};
   logic [31:0] v_imm   [6] = '{32'h12345000, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};
   logic [2:0]  v_type  [6] = '{3'd4, 3'd1, 3'd3, 3'd5, 3'd2, 3'd0};
   logic [6:0]  v_op    [6] = '{7'h37, 7'h13, 7'h63, 7'h6F, 7'h23, 7'h33};
   logic [4:0]  v_rd    [6] = '{5'd1, 5'd2, 5'd29, 5'd0, 5'd28, 5'd3};
   logic [2:0]  v_f3    [6] = '{3'd5, 3'd0, 3'd0, 3'd7, 3'd2, 3'd0};
   logic [4:0]  v_rs1   [6] = '{5'd8, 5'd0, 5'd0, 5'd31, 5'd1, 5'd1};
   logic [4:0]  v_rs2   [6] = '{5'd3, 5'd31, 5'd0, 5'd25, 5'd2, 5'd2};
   logic [6:0]  v_f7    [6] = '{7'h09, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h20};
   logic [19:0] v_uraw  [6] = '{20'h12345, 20'hFFF00, 20'hFE000, 20'hFF9FF, 20'hFE20A, 20'h40208};

   if_id_decode_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instr_in(instr_in), .pc_in(pc_in), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out), .pc_out(pc_out),
      .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
      .imm(imm), .imm_u_raw(imm_u_raw), .imm_type(imm_type)
`ifdef IFID_ILLEGAL_DET_EN
      , .illegal(illegal)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; instr_in = 32'h0; pc_in = 32'h0; flush = 1'b0; out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %h expected 0", out_valid); end
      total++; if (instr_out !== 32'h00000013) begin bad++; $display("[TB] FAIL reset_instr: got %h expected 00000013", instr_out); end
      total++; if (pc_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc: got %h expected 0", pc_out); end
      total++; if (imm !== 32'h0) begin bad++; $display("[TB] FAIL reset_imm: got %h expected 0", imm); end
      total++; if (imm_type !== 3'd1) begin bad++; $display("[TB] FAIL reset_type: got %0d expected 1", imm_type); end
      total++; if (opcode !== 7'h13) begin bad++; $display("[TB] FAIL reset_opcode: got %h expected 13", opcode); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %h expected 1", in_ready); end
`ifdef IFID_ILLEGAL_DET_EN
      total++; if (illegal !== 1'b0) begin bad++; $display("[TB] FAIL reset_illegal: got %h expected 0", illegal); end
`endif
   endtask

   // Consecutive beats with out_ready high: every cycle is a simultaneous drain and load.
   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1; instr_in = v_instr[k]; pc_in = 32'h100 + 32'(4 * k);
         step();
         total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL dec%0d_valid: got %h expected 1", k, out_valid); end
         total++; if (instr_out !== v_instr[k]) begin bad++; $display("[TB] FAIL dec%0d_instr: got %h expected %h", k, instr_out, v_instr[k]); end
         total++; if (pc_out !== 32'h100 + 32'(4 * k)) begin bad++; $display("[TB] FAIL dec%0d_pc: got %h expected %h", k, pc_out, 32'h100 + 32'(4 * k)); end
         total++; if (imm !== v_imm[k]) begin bad++; $display("[TB] FAIL dec%0d_imm: got %h expected %h", k, imm, v_imm[k]); end
         total++; if (imm_type !== v_type[k]) begin bad++; $display("[TB] FAIL dec%0d_type: got %0d expected %0d", k, imm_type, v_type[k]); end
         total++; if (opcode !== v_op[k]) begin bad++; $display("[TB] FAIL dec%0d_opcode: got %h expected %h", k, opcode, v_op[k]); end
         total++; if (rd !== v_rd[k]) begin bad++; $display("[TB] FAIL dec%0d_rd: got %0d expected %0d", k, rd, v_rd[k]); end
         total++; if (funct3 !== v_f3[k]) begin bad++; $display("[TB] FAIL dec%0d_funct3: got %0d expected %0d", k, funct3, v_f3[k]); end
         total++; if (rs1 !== v_rs1[k]) begin bad++; $display("[TB] FAIL dec%0d_rs1: got %0d expected %0d", k, rs1, v_rs1[k]); end
         total++; if (rs2 !== v_rs2[k]) begin bad++; $display("[TB] FAIL dec%0d_rs2: got %0d expected %0d", k, rs2, v_rs2[k]); end
         total++; if (funct7 !== v_f7[k]) begin bad++; $display("[TB] FAIL dec%0d_funct7: got %h expected %h", k, funct7, v_f7[k]); end
         total++; if (imm_u_raw !== v_uraw[k]) begin bad++; $display("[TB] FAIL dec%0d_uraw: got %h expected %h", k, imm_u_raw, v_uraw[k]); end
`ifdef IFID_ILLEGAL_DET_EN
         total++; if (illegal !== 1'b0) begin bad++; $display("[TB] FAIL dec%0d_illegal: got %h expected 0", k, illegal); end
`endif
      end
      in_valid = 1'b0;
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain_valid: got %h expected 0", out_valid); end
   endtask

   task automatic test_stall();
      out_ready = 1'b1; in_valid = 1'b1; instr_in = 32'h00A00093; pc_in = 32'h300;
      step();
      out_ready = 1'b0; instr_in = 32'h01400113; pc_in = 32'h304;
      #1;
      for (int c = 0; c < 3; c++) begin
         total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall%0d_in_ready: got %h expected 0", c, in_ready); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall%0d_valid: got %h expected 1", c, out_valid); end
         total++; if (instr_out !== 32'h00A00093) begin bad++; $display("[TB] FAIL stall%0d_instr: got %h expected 00a00093", c, instr_out); end
         total++; if (pc_out !== 32'h300) begin bad++; $display("[TB] FAIL stall%0d_pc: got %h expected 300", c, pc_out); end
         total++; if (imm !== 32'd10) begin bad++; $display("[TB] FAIL stall%0d_imm: got %h expected a", c, imm); end
         step();
      end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready: got %h expected 1", in_ready); end
      step();
      in_valid = 1'b0;
      total++; if (instr_out !== 32'h01400113) begin bad++; $display("[TB] FAIL release_instr: got %h expected 01400113", instr_out); end
      total++; if (pc_out !== 32'h304) begin bad++; $display("[TB] FAIL release_pc: got %h expected 304", pc_out); end
      total++; if (imm !== 32'd20) begin bad++; $display("[TB] FAIL release_imm: got %h expected 14", imm); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_valid: got %h expected 0", out_valid); end
      total++; if (instr_out !== 32'h01400113) begin bad++; $display("[TB] FAIL drain_hold: got %h expected 01400113", instr_out); end
   endtask

   task automatic test_flush();
      out_ready = 1'b1; in_valid = 1'b1; instr_in = 32'h00A00093; pc_in = 32'h400;
      step();
      out_ready = 1'b0; instr_in = 32'h0FF00193; pc_in = 32'h404;
      step();
      flush = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_in_ready: got %h expected 1", in_ready); end
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %h expected 0", out_valid); end
      total++; if (instr_out !== 32'h00000013) begin bad++; $display("[TB] FAIL flush_instr: got %h expected 00000013", instr_out); end
      total++; if (imm !== 32'h0) begin bad++; $display("[TB] FAIL flush_imm: got %h expected 0", imm); end
      total++; if (imm_type !== 3'd1) begin bad++; $display("[TB] FAIL flush_type: got %0d expected 1", imm_type); end
      total++; if (rd !== 5'd0) begin bad++; $display("[TB] FAIL flush_rd: got %0d expected 0", rd); end
      for (int c = 0; c < 2; c++) begin
         step();
         total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_ghost%0d: got %h expected 0", c, out_valid); end
      end
   endtask

   // Ten ADDI beats with gaps on both sides; each beat must come out exactly once, in order.
   task automatic test_stream();
      int sent = 0;
      int recv = 0;
      int cyc  = 0;
      logic [31:0] exp_instr;
      logic [31:0] exp_imm;
      while (recv < 10 && cyc < 80) begin
         in_valid  = (sent < 10) && (cyc % 5 != 3);
         instr_in  = {12'(sent * 3 + 1), 5'd0, 3'd0, 5'(sent + 1), 7'h13};
         pc_in     = 32'h200 + 32'(4 * sent);
         out_ready = (cyc % 4 != 2);
         #1;
         if (out_valid && out_ready) begin
            exp_instr = {12'(recv * 3 + 1), 5'd0, 3'd0, 5'(recv + 1), 7'h13};
            exp_imm   = 32'(recv * 3 + 1);
            total++; if (instr_out !== exp_instr) begin bad++; $display("[TB] FAIL stream%0d_instr: got %h expected %h", recv, instr_out, exp_instr); end
            total++; if (pc_out !== 32'h200 + 32'(4 * recv)) begin bad++; $display("[TB] FAIL stream%0d_pc: got %h expected %h", recv, pc_out, 32'h200 + 32'(4 * recv)); end
            total++; if (imm !== exp_imm) begin bad++; $display("[TB] FAIL stream%0d_imm: got %h expected %h", recv, imm, exp_imm); end
            recv++;
         end
         if (in_valid && in_ready) sent++;
         step();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      total++; if (recv !== 10) begin bad++; $display("[TB] FAIL stream_count: got %0d expected 10", recv); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_extra: got %h expected 0", out_valid); end
   endtask

   task automatic test_illegal_and_reset();
      out_ready = 1'b1; in_valid = 1'b1; instr_in = 32'h00000000; pc_in = 32'h500;
      step();
      out_ready = 1'b0; instr_in = 32'h00A00093; pc_in = 32'h504;
      total++; if (imm_type !== 3'd0) begin bad++; $display("[TB] FAIL unk_type: got %0d expected 0", imm_type); end
      total++; if (imm !== 32'h0) begin bad++; $display("[TB] FAIL unk_imm: got %h expected 0", imm); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL unk_valid: got %h expected 1", out_valid); end
`ifdef IFID_ILLEGAL_DET_EN
      total++; if (illegal !== 1'b1) begin bad++; $display("[TB] FAIL unk_illegal: got %h expected 1", illegal); end
`endif
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid: got %h expected 0", out_valid); end
      total++; if (instr_out !== 32'h00000013) begin bad++; $display("[TB] FAIL midrst_instr: got %h expected 00000013", instr_out); end
      total++; if (pc_out !== 32'h0) begin bad++; $display("[TB] FAIL midrst_pc: got %h expected 0", pc_out); end
`ifdef IFID_ILLEGAL_DET_EN
      total++; if (illegal !== 1'b0) begin bad++; $display("[TB] FAIL midrst_illegal: got %h expected 0", illegal); end
`endif
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_dropped: got %h expected 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_flush();
      test_stream();
      test_illegal_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
